// File: rtl/seq_add_controller.sv
// Multi-cycle adder/subtractor: adds one CHUNK-bit slice per cycle using a
// two-level carry-lookahead slice adder, with valid/ready handshakes on
// both the operation and the result side.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// RUN   | adding slice idx_q of the captured operands
// DONE  | result held on sum/c_out/overflow until out_ready
module seq_add_controller #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int NG = (CHUNK + 3) / 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             c_out_q, ovf_q;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout, chunk_msb_cin;
    logic             accept, last_chunk;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == RUN);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx_q == LAST_IDX);
    assign sum        = sum_q;
    assign c_out      = c_out_q;
    assign overflow   = ovf_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Slice adder: 4-bit groups, group carries expanded as flat lookahead
    // terms so no carry ripples from one group to the next.
    always_comb begin : cla
        logic [CHUNK-1:0] ca, cb, p, g, bc;
        logic [NG-1:0]    gp, gg;
        logic [NG:0]      gc;
        logic             term;
        ca   = a_q[int'(idx_q)*CHUNK +: CHUNK];
        cb   = b_q[int'(idx_q)*CHUNK +: CHUNK];
        p    = ca ^ cb;
        g    = ca & cb;
        gp   = '0;
        gg   = '0;
        gc   = '0;
        bc   = '0;
        term = 1'b0;
        for (int j = 0; j < NG; j++) begin
            gp[j] = 1'b1;
            gg[j] = 1'b0;
            for (int k = 4*j; k < 4*j + 4; k++) begin
                if (k < CHUNK) begin
                    gg[j] = g[k] | (p[k] & gg[j]);
                    gp[j] = gp[j] & p[k];
                end
            end
        end
        gc[0] = carry_q;
        for (int j = 1; j <= NG; j++) begin
            term = carry_q;
            for (int m = 0; m < j; m++) term = term & gp[m];
            gc[j] = term;
            for (int k = 0; k < j; k++) begin
                term = gg[k];
                for (int m = k + 1; m < j; m++) term = term & gp[m];
                gc[j] = gc[j] | term;
            end
        end
        for (int j = 0; j < NG; j++) bc[4*j] = gc[j];
        for (int k = 0; k < CHUNK - 1; k++) begin
            if (((k + 1) % 4) != 0) bc[k+1] = g[k] | (p[k] & bc[k]);
        end
        chunk_sum     = p ^ bc;
        chunk_cout    = gc[NG];
        chunk_msb_cin = bc[CHUNK-1];
    end

    // Operand capture and per-slice accumulation; B is pre-inverted for subtract.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b ^ {WIDTH{sub}};
                carry_q <= sub | c_in;
                idx_q   <= '0;
            end
        end else if (state_q == RUN) begin
            sum_q[int'(idx_q)*CHUNK +: CHUNK] <= chunk_sum;
            carry_q <= chunk_cout;
            if (last_chunk) begin
                c_out_q <= chunk_cout;
                ovf_q   <= chunk_msb_cin ^ chunk_cout;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_add_controller.sv
// Randomised bench for seq_add_controller: a negedge monitor pushes the
// arithmetic expectation when it sees an operation about to be accepted and
// compares it against every cycle the result is presented.
module tb_seq_add_controller;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             busy;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   issued = 0;
    int   seen = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   busy_cnt = 0;
    logic prev_ov = 1'b0;

    seq_add_controller #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: full-width arithmetic, signed overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        exp_t            e;
        logic [WIDTH:0]  r;
        if (s) r = {1'b0, x} - {1'b0, y} + {{WIDTH{1'b0}}, 1'b1} + {1'b0, {WIDTH{1'b1}}};
        else   r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        e.s = r[WIDTH-1:0];
        e.c = r[WIDTH];
        if (s) e.v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        else   e.v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            prev_ov = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (!prev_ov) begin
                    // acc_cyc is the negedge just before the accepting edge
                    check("latency", 64'(cyc - acc_cyc), 64'(N + 1));
                    check("busy_cycles", 64'(busy_cnt), 64'(N));
                end
                check("in_ready_in_done", 64'(in_ready), 64'd0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got sum %0h expected no result", sum);
                end else begin
                    check("sum", 64'(sum), 64'(q[0].s));
                    check("c_out", 64'(c_out), 64'(q[0].c));
                    check("overflow", 64'(overflow), 64'(q[0].v));
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, sub));
                acc_cyc  = cyc;
                busy_cnt = 0;
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("timeout_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic scramble();
        a    = $urandom;
        b    = $urandom;
        c_in = 1'($urandom);
        sub  = 1'($urandom);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input logic ts, input int hold, input bit noisy);
        int n = 0;
        wait_ready();
        a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        issued++;
        if (!noisy) in_valid = 1'b0;
        while (!out_valid && n < 30) begin
            if (noisy) begin
                scramble();
                out_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("timeout_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        repeat (hold) begin
            if (noisy) scramble();
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_handshake_out_valid", 64'(out_valid), 64'd0);
        check("post_handshake_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sum"}, 64'(sum), 64'd0);
        check({tag, "_c_out"}, 64'(c_out), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return {1'b1, {(WIDTH-1){1'b0}}};
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return '0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);

        // Abort mid-RUN: upper byte of sum still holds 0x80 from the last result.
        wait_ready();
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        @(posedge clk);
        #2 rst = 1'b0;
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);

        run_op(32'd5, 32'd7, 1'b1, 1'b1, 0, 1'b0);
        run_op(32'd7, 32'd5, 1'b0, 1'b1, 0, 1'b0);
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op(pick(), pick(), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("handshakes", 64'(seen), 64'(issued));
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule
